sprite_layer_engine: RTL and testbench

//  Parametrised sprite plane for the VGA pipeline. Holds N_CHILD sprites in ping-pong state banks and

---
 rtl/sprite_layer_engine_if.sv | 17 +
 rtl/sprite_layer_engine.sv | 136 +++++++++++++
 tb/tb_sprite_layer_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_layer_engine_if.sv
// sprite_layer_engine_if: command bus, raster position and pixel/flush outputs of the sprite plane
//   write, writedata : Avalon command word and its qualifier
//   hcount, vcount   : current raster position
//   RGB_output       : pixel colour, two clocks behind hcount/vcount
//   flush_pending    : flush accepted, waiting for the frame boundary
//   frame_swap       : one-clock pulse when the front bank changes
interface sprite_layer_engine_if;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [23:0] RGB_output;
  logic        flush_pending;
  logic        frame_swap;
  modport master (output write, writedata, hcount, vcount, input RGB_output, flush_pending, frame_swap);
  modport slave (input write, writedata, hcount, vcount, output RGB_output, flush_pending, frame_swap);
endinterface

// File: rtl/sprite_layer_engine.sv
// sprite_layer_engine: ping-pong sprite plane with frame-boundary flush and 2-stage pixel pipe
//   clk   : pixel/system clock
//   reset : asynchronous, active-low
//   bus   : command word, raster position in; RGB_output, flush_pending, frame_swap out
//   ROM_INIT holds the packed pattern ROM image, word w at bits [w*MEM_W +: MEM_W]
module sprite_layer_engine #(
  parameter logic [5:0] SUB_COMP_ID = 6'd9,
  parameter int N_CHILD = 4,
  parameter int N_PATTERN = 2,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int PIX_BITS = 2,
  parameter int MEM_W = 4,
  parameter int MEM_DEPTH = 256,
  parameter int TRANSP_IDX = 0,
  parameter logic [23:0] BG_RGB = 24'h202020,
  parameter int V_ACTIVE = 480,
  parameter logic [MEM_DEPTH*MEM_W-1:0] ROM_INIT = '0
) (
  input logic clk,
  input logic reset,
  sprite_layer_engine_if.slave bus
);
  localparam int PPW = MEM_W / PIX_BITS;
  localparam int ADDR_LIMIT = MEM_DEPTH * PPW;
  localparam int AW = $clog2(ADDR_LIMIT + 1);
  localparam int NPAL = 2 ** PIX_BITS;
  logic [5:0] sub;
  logic [4:0] child;
  logic [3:0] info;
  logic [2:0] typ;
  logic pp;
  logic [12:0] msg;
  logic set_cmd, flush, commit;
  logic vis_q [2][N_CHILD], vis_d [2][N_CHILD];
  logic flip_q [2][N_CHILD], flip_d [2][N_CHILD];
  logic [4:0] pat_q [2][N_CHILD], pat_d [2][N_CHILD];
  logic [9:0] x_q [2][N_CHILD], x_d [2][N_CHILD];
  logic [9:0] y_q [2][N_CHILD], y_d [2][N_CHILD];
  logic [9:0] shf_q [2][N_CHILD], shf_d [2][N_CHILD];
  logic [23:0] pal_q [NPAL], pal_d [NPAL];
  logic front_q, front_d, tgt_q, tgt_d, pend_q, pend_d, swap_q, swap_d;
  logic [N_CHILD-1:0] hit_q, hit_d, opq;
  logic [AW-1:0] addr_q [N_CHILD], addr_d [N_CHILD];
  logic [PIX_BITS-1:0] idx [N_CHILD];
  logic [23:0] rgb_q, rgb_d;
  assign {sub, child, info, typ, pp, msg} = bus.writedata;
  assign set_cmd = bus.write && sub == SUB_COMP_ID && info == 4'h1;
  assign flush = bus.write && sub == SUB_COMP_ID && info == 4'hF;
  assign commit = pend_q && bus.vcount == 10'(V_ACTIVE) && bus.hcount == '0;
  always_comb begin
    vis_d = vis_q;
    flip_d = flip_q;
    pat_d = pat_q;
    x_d = x_q;
    y_d = y_q;
    shf_d = shf_q;
    pal_d = pal_q;
    for (int i = 0; i < N_CHILD; i++) begin
      if (set_cmd && int'(child) == i) begin
        if (typ == 3'b001) begin
          vis_d[pp][i] = msg[12];
          flip_d[pp][i] = msg[11];
          if (int'(msg[4:0]) < N_PATTERN) pat_d[pp][i] = msg[4:0];
        end
        if (typ == 3'b010) x_d[pp][i] = msg[9:0];
        if (typ == 3'b011) y_d[pp][i] = msg[9:0];
        if (typ == 3'b100) shf_d[pp][i] = msg[9:0];
      end
    end
    for (int j = 0; j < NPAL; j++) begin
      if (set_cmd && int'(child) == j && typ == 3'b101) pal_d[j][11:0] = msg[11:0];
      if (set_cmd && int'(child) == j && typ == 3'b110) pal_d[j][23:12] = msg[11:0];
    end
    // the commit clear comes after the command writes so it wins a same-cycle visible write
    for (int i = 0; i < N_CHILD; i++) if (commit) vis_d[~tgt_q][i] = 1'b0;
    front_d = commit ? tgt_q : front_q;
    tgt_d = flush ? pp : tgt_q;
    pend_d = flush || (pend_q && !commit);
    swap_d = commit;
  end
  for (genvar i = 0; i < N_CHILD; i++) begin : g_slot
    logic [10:0] col, row;
    int lin;
    assign col = {1'b0, bus.hcount} - {1'b0, x_q[front_q][i]};
    assign row = {1'b0, bus.vcount} - {1'b0, y_q[front_q][i]};
    assign lin = int'(pat_q[front_q][i]) * SPR_W * SPR_H + int'(shf_q[front_q][i]) + int'(row[9:0]) * SPR_W
               + (flip_q[front_q][i] ? SPR_W - 1 - int'(col[9:0]) : int'(col[9:0]));
    // col/row bit 10 set means the pixel lies left of / above the sprite
    assign hit_d[i] = vis_q[front_q][i] && !col[10] && int'(col[9:0]) < SPR_W
                   && !row[10] && int'(row[9:0]) < SPR_H && lin < ADDR_LIMIT;
    assign addr_d[i] = AW'(lin);
    assign idx[i] = PIX_BITS'(ROM_INIT >> ((int'(addr_q[i]) / PPW) * MEM_W + (int'(addr_q[i]) % PPW) * PIX_BITS));
    assign opq[i] = hit_q[i] && int'(idx[i]) != TRANSP_IDX;
  end
  always_comb begin
    rgb_d = BG_RGB;
    for (int i = N_CHILD - 1; i >= 0; i--) if (opq[i]) rgb_d = pal_q[idx[i]];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vis_q <= '{default: '0};
      flip_q <= '{default: '0};
      pat_q <= '{default: '0};
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      shf_q <= '{default: '0};
      pal_q <= '{default: '0};
      front_q <= 1'b0;
      tgt_q <= 1'b0;
      pend_q <= 1'b0;
      swap_q <= 1'b0;
      hit_q <= '0;
      addr_q <= '{default: '0};
      rgb_q <= BG_RGB;
    end else begin
      vis_q <= vis_d;
      flip_q <= flip_d;
      pat_q <= pat_d;
      x_q <= x_d;
      y_q <= y_d;
      shf_q <= shf_d;
      pal_q <= pal_d;
      front_q <= front_d;
      tgt_q <= tgt_d;
      pend_q <= pend_d;
      swap_q <= swap_d;
      hit_q <= hit_d;
      addr_q <= addr_d;
      rgb_q <= rgb_d;
    end
  end
  assign bus.RGB_output = rgb_q;
  assign bus.flush_pending = pend_q;
  assign bus.frame_swap = swap_q;
endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb_sprite_layer_engine: vector table, corner sequences and random commands against a reference model
module tb_sprite_layer_engine;
  localparam logic [23:0] BG = 24'h202020;
  function automatic logic [3:0] rom_word(int i);
    return 4'(((i * 7) + (i >> 3)) ^ 5);
  endfunction
  function automatic logic [1023:0] build_rom();
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[i*4 +: 4] = rom_word(i);
    return r;
  endfunction
  localparam logic [1023:0] ROM_IMG = build_rom();
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  sprite_layer_engine_if bus ();
  sprite_layer_engine #(.ROM_INIT(ROM_IMG)) dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  bit m_vis [2][4];
  bit m_flip [2][4];
  int m_pat [2][4], m_x [2][4], m_y [2][4], m_sh [2][4];
  logic [23:0] m_pal [4];
  int m_front, m_tgt, m_stage;
  bit m_pend;
  logic [23:0] e_rgb;
  bit e_pend, e_swap;
  typedef struct {
    bit flip;
    int h;
    int v;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask
  function automatic int rom_pix(int a);
    return int'((rom_word(a / 2) >> ((a % 2) * 2)) & 4'h3);
  endfunction
  function automatic int pixel_of(int h, int v);
    for (int i = 0; i < 4; i++) begin
      int col, row, a, p;
      col = h - m_x[m_front][i];
      row = v - m_y[m_front][i];
      if (!m_vis[m_front][i] || col < 0 || col > 15 || row < 0 || row > 15) continue;
      a = m_pat[m_front][i] * 256 + m_sh[m_front][i] + row * 16 + (m_flip[m_front][i] ? 15 - col : col);
      if (a >= 512) continue;
      p = rom_pix(a);
      if (p != 0) return p;
    end
    return -1;
  endfunction
  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4; i++) begin
        m_vis[b][i] = 0; m_flip[b][i] = 0; m_pat[b][i] = 0;
        m_x[b][i] = 0; m_y[b][i] = 0; m_sh[b][i] = 0;
      end
    for (int j = 0; j < 4; j++) m_pal[j] = '0;
    m_front = 0; m_tgt = 0; m_pend = 0; m_stage = -1;
    e_rgb = BG; e_pend = 0; e_swap = 0;
  endtask
  task automatic model_edge(input logic w, input logic [31:0] wd, input int h, input int v);
    int ch, t, b, win;
    bit commit, ours;
    win = pixel_of(h, v);
    e_rgb = m_stage < 0 ? BG : m_pal[m_stage];
    m_stage = win;
    commit = m_pend && v == 480 && h == 0;
    ch = int'(wd[25:21]); t = int'(wd[16:14]); b = int'(wd[13]);
    ours = w && wd[31:26] == 6'd9;
    if (ours && wd[20:17] == 4'h1 && ch < 4) begin
      case (t)
        1: begin
          m_vis[b][ch] = wd[12];
          m_flip[b][ch] = wd[11];
          if (wd[4:0] < 5'd2) m_pat[b][ch] = int'(wd[4:0]);
        end
        2: m_x[b][ch] = int'(wd[9:0]);
        3: m_y[b][ch] = int'(wd[9:0]);
        4: m_sh[b][ch] = int'(wd[9:0]);
        5: m_pal[ch][11:0] = wd[11:0];
        6: m_pal[ch][23:12] = wd[11:0];
        default: ;
      endcase
    end
    if (commit) begin
      m_front = m_tgt;
      for (int i = 0; i < 4; i++) m_vis[1 - m_tgt][i] = 0;
    end
    if (ours && wd[20:17] == 4'hF) begin
      m_tgt = b;
      m_pend = 1;
    end else if (commit) m_pend = 0;
    e_pend = m_pend;
    e_swap = commit;
  endtask
  task automatic step(input logic w, input logic [31:0] wd, input int h, input int v);
    bus.write = w; bus.writedata = wd; bus.hcount = 10'(h); bus.vcount = 10'(v);
    model_edge(w, wd, h, v);
    @(posedge clk); #1;
    chk("rgb", bus.RGB_output, e_rgb);
    chk("pend", bus.flush_pending, e_pend);
    chk("swap", bus.frame_swap, e_swap);
  endtask
  function automatic logic [31:0] cmd(int info, int t, int ch, int pp, int msg);
    return {6'd9, 5'(ch), 4'(info), 3'(t), 1'(pp), 13'(msg)};
  endfunction
  task automatic wr(input int t, input int ch, input int pp, input int msg);
    step(1'b1, cmd(1, t, ch, pp, msg), 0, 0);
  endtask
  task automatic fl(input int pp);
    step(1'b1, cmd(15, 0, 0, pp, 0), 5, 200);
  endtask
  task automatic commit_now();
    step(1'b0, '0, 0, 480);
  endtask
  task automatic pix(input int h, input int v, input logic [23:0] exp, input string nm);
    step(1'b0, '0, h, v);
    step(1'b0, '0, 0, 0);
    chk(nm, bus.RGB_output, exp);
  endtask
  initial begin
    tbl[0] = '{0, 100, 50, 24'he69c21};  tbl[1] = '{0, 99, 50, BG};
    tbl[2] = '{0, 116, 50, BG};          tbl[3] = '{0, 101, 50, 24'he69c21};
    tbl[4] = '{0, 102, 50, 24'h123456};  tbl[5] = '{0, 104, 50, 24'habcdef};
    tbl[6] = '{0, 106, 50, BG};          tbl[7] = '{0, 115, 50, 24'he69c21};
    tbl[8] = '{0, 100, 49, BG};          tbl[9] = '{0, 100, 66, BG};
    tbl[10] = '{0, 101, 51, 24'habcdef}; tbl[11] = '{0, 100, 65, 24'h123456};
    tbl[12] = '{1, 100, 50, 24'he69c21}; tbl[13] = '{1, 101, 50, BG};
    tbl[14] = '{1, 115, 50, 24'he69c21}; tbl[15] = '{1, 113, 50, 24'h123456};
    tbl[16] = '{1, 100, 51, 24'habcdef}; tbl[17] = '{1, 100, 65, 24'habcdef};
    bus.write = 1'b0; bus.writedata = '0; bus.hcount = '0; bus.vcount = '0;
    model_reset();
    #12;
    chk("reset_rgb", bus.RGB_output, BG);
    chk("reset_pend", bus.flush_pending, 1'b0);
    chk("reset_swap", bus.frame_swap, 1'b0);
    reset = 1'b1;
    wr(5, 1, 0, 'hc21); wr(6, 1, 0, 'he69);
    wr(5, 2, 0, 'h456); wr(6, 2, 0, 'h123);
    wr(5, 3, 0, 'hdef); wr(6, 3, 0, 'habc);
    wr(1, 0, 0, 'h1000); wr(2, 0, 0, 100); wr(3, 0, 0, 50); wr(4, 0, 0, 0);
    fl(0);
    step(1'b0, '0, 5, 300);
    chk("pend_wait", bus.flush_pending, 1'b1);
    commit_now();
    chk("swap_pulse", bus.frame_swap, 1'b1);
    step(1'b0, '0, 1, 480);
    chk("swap_once", bus.frame_swap, 1'b0);
    for (int k = 0; k < 18; k++) begin
      wr(1, 0, 0, 'h1000 | (int'(tbl[k].flip) << 11));
      pix(tbl[k].h, tbl[k].v, tbl[k].exp, $sformatf("tbl%0d", k));
    end
    wr(1, 0, 0, 'h1000);
    wr(1, 1, 0, 'h1000); wr(2, 1, 0, 100); wr(3, 1, 0, 50); wr(4, 1, 0, 4);
    pix(100, 50, 24'he69c21, "prio_slot0");
    pix(106, 50, 24'h123456, "prio_slot1");
    wr(1, 1, 0, 0);
    wr(1, 0, 0, 'h1005);
    pix(100, 50, 24'he69c21, "pattern_ignored");
    wr(4, 0, 0, 511);
    pix(100, 50, 24'habcdef, "addr_last");
    wr(4, 0, 0, 512);
    pix(100, 50, BG, "addr_limit");
    wr(4, 0, 0, 0);
    step(1'b1, cmd(1, 2, 7, 0, 0), 0, 0);
    pix(100, 50, 24'he69c21, "child7");
    fl(1);
    step(1'b0, '0, 50, 300);
    chk("pend_hold", bus.flush_pending, 1'b1);
    step(1'b0, '0, 1, 480);
    chk("no_commit_h1", bus.flush_pending, 1'b1);
    commit_now();
    chk("swap_a", bus.frame_swap, 1'b1);
    chk("pend_a", bus.flush_pending, 1'b0);
    pix(100, 50, BG, "front1_empty");
    fl(0); commit_now();
    pix(100, 50, BG, "bank0_cleared");
    wr(1, 0, 0, 'h1000);
    pix(100, 50, 24'he69c21, "front_write");
    fl(1); fl(0);
    chk("pend_b", bus.flush_pending, 1'b1);
    commit_now();
    pix(100, 50, 24'he69c21, "flush_overwrite");
    fl(0);
    step(1'b1, cmd(15, 0, 0, 1, 0), 0, 480);
    chk("commit_flush_swap", bus.frame_swap, 1'b1);
    chk("commit_flush_pend", bus.flush_pending, 1'b1);
    commit_now();
    fl(0);
    step(1'b1, cmd(1, 1, 0, 1, 'h1000), 0, 480);
    fl(1); commit_now();
    pix(0, 0, BG, "clear_wins");
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] wd;
      int t, msg, h, v;
      t = int'($urandom_range(0, 7));
      if (t == 1) msg = (int'($urandom_range(0, 3) != 0) << 12) | (int'($urandom_range(0, 1)) << 11)
                      | (int'($urandom_range(0, 63)) << 5) | int'($urandom_range(0, 5));
      else if (t == 2 || t == 3) msg = int'($urandom_range(0, 110));
      else if (t == 4) msg = int'($urandom_range(0, 520));
      else msg = int'($urandom_range(0, 8191));
      wd = {($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd9, 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0) ? 4'hF : (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h1),
            3'(t), 1'($urandom), 13'(msg)};
      h = int'($urandom_range(0, 127));
      v = int'($urandom_range(0, 127));
      if (n % 37 == 0) begin
        h = 0;
        v = 480;
      end
      step($urandom_range(0, 1) == 1, wd, h, v);
    end
    fl(1);
    reset = 1'b0;
    model_reset();
    #3;
    chk("rst_async_rgb", bus.RGB_output, BG);
    chk("rst_async_pend", bus.flush_pending, 1'b0);
    @(posedge clk); #1;
    chk("rst_rgb", bus.RGB_output, BG);
    chk("rst_pend", bus.flush_pending, 1'b0);
    chk("rst_swap", bus.frame_swap, 1'b0);
    reset = 1'b1;
    fl(0); commit_now();
    pix(0, 0, BG, "rst_bank0");
    fl(1); commit_now();
    pix(0, 0, BG, "rst_bank1");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
